// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes a pair of WIDTH-bit operands MSB first for the serial comparator,
// preceded by a one-cycle clear pulse; back-to-back pairs need no idle gap.
module serial_pair_serializer_msb_first #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_clear,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;

    logic             at_last;
    logic             accept;
    logic [WIDTH-1:0] sh_a_nxt;
    logic [WIDTH-1:0] sh_b_nxt;
    logic [CW-1:0]    cnt_inc;

    // Ready is decoded from state only so a source cannot form a comb loop through it.
    assign at_last  = (state == S_SHIFT) && (cnt == CNT_LAST);
    assign in_ready = rst && ((state == S_IDLE) || at_last);
    assign accept   = in_valid && in_ready;
    assign sh_a_nxt = sh_a << 1;
    assign sh_b_nxt = sh_b << 1;
    assign cnt_inc  = cnt + CW'(1);

    // Outputs are registered from the values the state is about to take,
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            out_clear <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_clear <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sh_a      <= in_a;
                        sh_b      <= in_b;
                        state     <= S_CLEAR;
                        out_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state     <= S_SHIFT;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    out_valid <= 1'b1;
                    out_a     <= sh_a[WIDTH-1];
                    out_b     <= sh_b[WIDTH-1];
                    out_first <= 1'b1;
                    out_last  <= (CNT_LAST == '0);
                end
                S_SHIFT: begin
                    sh_a <= sh_a_nxt;
                    sh_b <= sh_b_nxt;
                    if (at_last) begin
                        cnt <= '0;
                        if (accept) begin
                            sh_a      <= in_a;
                            sh_b      <= in_b;
                            state     <= S_CLEAR;
                            out_clear <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt       <= cnt_inc;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_a     <= sh_a_nxt[WIDTH-1];
                        out_b     <= sh_b_nxt[WIDTH-1];
                        out_last  <= (cnt_inc == CNT_LAST);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Scoreboard bench for serial_pair_serializer_msb_first (WIDTH=8 and WIDTH=1 instances).
module tb_serial_pair_serializer_msb_first;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } bit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_clear, out_valid, out_a, out_b, out_first, out_last, busy;

    logic       v1;
    logic       r1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       clr1, ov1, oa1, ob1, of1, ol1, busy1;

    bit_t sb8[$];
    bit_t sb1[$];
    bit_t exp8, got8, exp1, got1;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_pair_serializer_msb_first #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_clear(out_clear), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    serial_pair_serializer_msb_first #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_b(b1), .out_clear(clr1), .out_valid(ov1),
        .out_a(oa1), .out_b(ob1), .out_first(of1), .out_last(ol1),
        .busy(busy1)
    );

    function automatic void push8(input logic [7:0] a, input logic [7:0] b);
        bit_t e;
        for (int i = 7; i >= 0; i--) begin
            e.a     = a[i];
            e.b     = b[i];
            e.first = (i == 7);
            e.last  = (i == 0);
            sb8.push_back(e);
        end
    endfunction

    function automatic void push1(input logic a, input logic b);
        bit_t e;
        e.a     = a;
        e.b     = b;
        e.first = 1'b1;
        e.last  = 1'b1;
        sb1.push_back(e);
    endfunction

    // Stream monitors: every valid bit must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if ((out_clear && out_valid) ||
                (!out_valid && (out_a || out_b || out_first || out_last)))
                $display("FAIL gate8: clear=%b valid=%b a=%b b=%b first=%b last=%b",
                         out_clear, out_valid, out_a, out_b, out_first, out_last);
            else n_pass++;
            if (out_valid) begin
                n_checks++;
                got8 = '{a: out_a, b: out_b, first: out_first, last: out_last};
                if (sb8.size() == 0) begin
                    $display("FAIL stream8: unexpected bit %b, none expected", got8);
                end else begin
                    exp8 = sb8.pop_front();
                    if (got8 !== exp8)
                        $display("FAIL stream8: got a/b/first/last %b expected %b", got8, exp8);
                    else n_pass++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if ((clr1 && ov1) || (!ov1 && (oa1 || ob1 || of1 || ol1)))
                $display("FAIL gate1: clear=%b valid=%b a=%b b=%b first=%b last=%b",
                         clr1, ov1, oa1, ob1, of1, ol1);
            else n_pass++;
            if (ov1) begin
                n_checks++;
                got1 = '{a: oa1, b: ob1, first: of1, last: ol1};
                if (sb1.size() == 0) begin
                    $display("FAIL stream1: unexpected bit %b, none expected", got1);
                end else begin
                    exp1 = sb1.pop_front();
                    if (got1 !== exp1)
                        $display("FAIL stream1: got a/b/first/last %b expected %b", got1, exp1);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_clear, out_valid, out_a, out_b, out_first, out_last, busy,
                 r1, clr1, ov1, busy1} !== 12'h000)
                $display("FAIL reset_outputs: got %b expected all zero",
                         {in_ready, out_clear, out_valid, out_a, out_b, out_first,
                          out_last, busy, r1, clr1, ov1, busy1});
            else n_pass++;
        end
        in_valid = 1'b0; v1 = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || r1 !== 1'b1)
            $display("FAIL reset_release_ready: got %b%b expected 11", in_ready, r1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy, out_clear} !== 3'b100)
            $display("FAIL reset_idle: ready/busy/clear got %b expected 100",
                     {in_ready, busy, out_clear});
        else n_pass++;
    endtask

    task automatic test_single();
        logic gt, lt;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", in_ready);
        else n_pass++;
        in_valid = 1'b1; in_a = 8'h64; in_b = 8'h62;
        push8(8'h64, 8'h62);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_clear, out_valid, busy, in_ready} !== 4'b1010)
            $display("FAIL single_clear: clear/valid/busy/ready got %b expected 1010",
                     {out_clear, out_valid, busy, in_ready});
        else n_pass++;
        gt = 1'b0; lt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL single_valid[%0d]: got %b expected 1", i, out_valid);
            else n_pass++;
            if (!gt && !lt) begin
                if (out_a && !out_b) gt = 1'b1;
                else if (!out_a && out_b) lt = 1'b1;
            end
            if (i == 7) begin
                n_checks++;
                if ({out_last, gt, lt} !== 3'b110)
                    $display("FAIL single_verdict: last/gt/lt got %b expected 110", {out_last, gt, lt});
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, out_clear, in_ready} !== 4'b0001)
            $display("FAIL single_idle: valid/busy/clear/ready got %b expected 0001",
                     {out_valid, busy, out_clear, in_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  busy_n, clears;
        logic pushed;
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hA5; in_b = 8'hA5;
        push8(8'hA5, 8'hA5);
        @(negedge clk);
        in_a = 8'h0F; in_b = 8'hF0;
        busy_n = 0; clears = 0; pushed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (out_clear) clears++;
            if (!pushed && in_ready) begin
                n_checks++;
                if ({out_valid, out_last} !== 2'b11)
                    $display("FAIL b2b_accept_on_last: valid/last got %b expected 11",
                             {out_valid, out_last});
                else n_pass++;
                push8(8'h0F, 8'hF0);
                pushed = 1'b1;
            end else if (pushed) begin
                in_valid = 1'b0;
            end
            if (!busy) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (busy_n != 18) $display("FAIL b2b_cycles: got %0d expected 18", busy_n);
        else n_pass++;
        n_checks++;
        if (clears != 2) $display("FAIL b2b_clears: got %0d expected 2", clears);
        else n_pass++;
    endtask

    task automatic test_stall();
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h3C; in_b = 8'hC3;
        push8(8'h3C, 8'hC3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready);
                else n_pass++;
                in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00;
            end else begin
                in_valid = 1'b0;
            end
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        n_checks++;
        if ({busy, in_ready} !== 2'b01)
            $display("FAIL stall_end: busy/ready got %b expected 01", {busy, in_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hC3;
        push8(8'h5A, 8'hC3);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_clear, out_valid, out_a, out_b, out_first, out_last, busy} !== 8'h00)
            $display("FAIL midreset_outputs: got %b expected 00000000",
                     {in_ready, out_clear, out_valid, out_a, out_b, out_first, out_last, busy});
        else n_pass++;
        sb8.delete();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_a = 8'h81; in_b = 8'h7E;
        #1;
        n_checks++;
        if ({in_ready, busy} !== 2'b10)
            $display("FAIL midreset_release: ready/busy got %b expected 10", {in_ready, busy});
        else n_pass++;
        push8(8'h81, 8'h7E);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_clear, out_valid} !== 2'b10)
            $display("FAIL midreset_fresh_clear: clear/valid got %b expected 10", {out_clear, out_valid});
        else n_pass++;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midreset_finish: busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_width1();
        int   busy_n, clears;
        logic pushed;
        @(negedge clk);
        n_checks++;
        if (r1 !== 1'b1) $display("FAIL w1_ready: got %b expected 1", r1);
        else n_pass++;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        push1(1'b1, 1'b0);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1;
        n_checks++;
        if ({clr1, r1} !== 2'b10) $display("FAIL w1_clear: clear/ready got %b expected 10", {clr1, r1});
        else n_pass++;
        busy_n = 0; clears = 0; pushed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy1) busy_n++;
            if (clr1) clears++;
            if (!pushed && r1) begin
                n_checks++;
                if ({ov1, of1, ol1} !== 3'b111)
                    $display("FAIL w1_ready_in_shift: valid/first/last got %b expected 111",
                             {ov1, of1, ol1});
                else n_pass++;
                push1(1'b0, 1'b1);
                pushed = 1'b1;
            end else if (pushed) begin
                v1 = 1'b0;
            end
            if (!busy1) break;
            @(negedge clk);
        end
        v1 = 1'b0;
        n_checks++;
        if (busy_n != 4) $display("FAIL w1_cycles: got %0d expected 4", busy_n);
        else n_pass++;
        n_checks++;
        if (clears != 2) $display("FAIL w1_clears: got %0d expected 2", clears);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        v1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width1();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb8.size() != 0 || sb1.size() != 0)
            $display("FAIL drain: pending bits got %0d/%0d expected 0/0", sb8.size(), sb1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
